gsu_mem_arbiter: RTL and testbench

Arbitrates the single shared cartridge memory port (ROM and save RAM on SRAM0) between three requesters: SNES bus, MCU, and GSU core. Sits between the address-mapping logic, which supplies the already-translated 24-bit SNES memory address, and the external memory pins. Each access is a fixed-length timed cycle. SNES gets absolute priority; a starvation guard bounds GSU wait behind the MCU.

---
 rtl/gsu_mem_arbiter_pkg.sv | 28 ++
 rtl/gsu_mem_arb_pick.sv | 30 +++
 rtl/gsu_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_gsu_mem_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gsu_mem_arbiter_pkg.sv
// Shared types and encodings for the GSU cartridge memory arbiter.
// Owner IDs and state codes match the encodings the memory-map logic expects.
package gsu_mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic [1:0] OWN_SNES = 2'd0;
  localparam logic [1:0] OWN_MCU  = 2'd1;
  localparam logic [1:0] OWN_GSU  = 2'd2;

  typedef struct packed {
    logic [23:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } mem_req_t;

  function automatic mem_req_t mk_req(input logic [23:0] a, input logic w, input logic [7:0] d);
    mem_req_t r;
    r.addr  = a;
    r.we    = w;
    r.wdata = d;
    return r;
  endfunction

endpackage

// File: rtl/gsu_mem_arb_pick.sv
// Combinational priority picker: SNES first, then GSU when starved, then MCU, then GSU.
module gsu_mem_arb_pick
  import gsu_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 2
) (
  input  logic       snes_pend,
  input  logic       mcu_req,
  input  logic       gsu_req,
  input  logic [1:0] starve,
  output logic       gnt_vld,
  output logic [1:0] gnt_own
);

  always_comb begin
    gnt_vld = 1'b1;
    gnt_own = OWN_SNES;
    if (snes_pend)
      gnt_own = OWN_SNES;
    else if (gsu_req && starve == 2'(STARVE_LIMIT))
      gnt_own = OWN_GSU;
    else if (mcu_req)
      gnt_own = OWN_MCU;
    else if (gsu_req)
      gnt_own = OWN_GSU;
    else
      gnt_vld = 1'b0;
  end

endmodule

// File: rtl/gsu_mem_arbiter.sv
// Shared cartridge memory port arbiter (SNES / MCU / GSU), fixed-length timed accesses.
// ACK/RDY pulse the cycle after the last access cycle, when the arbiter is already idle.
module gsu_mem_arbiter
  import gsu_mem_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES = 6,
  parameter int STARVE_LIMIT  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SNES_REQ,
  input  logic [23:0] SNES_ADDR,
  input  logic        SNES_WE,
  input  logic [7:0]  SNES_WDATA,
  output logic [7:0]  SNES_RDATA,
  output logic        SNES_RDY,
  input  logic        MCU_REQ,
  input  logic [23:0] MCU_ADDR,
  input  logic        MCU_WE,
  input  logic [7:0]  MCU_WDATA,
  output logic [7:0]  MCU_RDATA,
  output logic        MCU_ACK,
  input  logic        GSU_REQ,
  input  logic [23:0] GSU_ADDR,
  input  logic        GSU_WE,
  input  logic [7:0]  GSU_WDATA,
  output logic [7:0]  GSU_RDATA,
  output logic        GSU_ACK,
  output logic [23:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  input  logic [7:0]  MEM_RDATA,
  output logic        MEM_OE,
  output logic        MEM_WE
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] WE_LAST  = 4'(ACCESS_CYCLES - 2);

  state_e     state, nstate;
  logic [3:0] cnt;
  logic [1:0] owner;
  logic       acc_we;
  logic [1:0] starve;
  logic       snes_pend;
  mem_req_t   snes_q, snes_cur, win;
  logic       snes_vld, mcu_m, gsu_m, gnt_vld, grant;
  logic [1:0] gnt_own;

  // A pulse in the arbitration cycle itself competes immediately with its fresh values.
  assign snes_vld = snes_pend | SNES_REQ;
  assign snes_cur = SNES_REQ ? mk_req(SNES_ADDR, SNES_WE, SNES_WDATA) : snes_q;
  assign mcu_m    = MCU_REQ & ~MCU_ACK;
  assign gsu_m    = GSU_REQ & ~GSU_ACK;

  gsu_mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .snes_pend (snes_vld),
    .mcu_req   (mcu_m),
    .gsu_req   (gsu_m),
    .starve    (starve),
    .gnt_vld   (gnt_vld),
    .gnt_own   (gnt_own)
  );

  assign grant = (state == ST_IDLE) && gnt_vld;

  always_comb begin
    win = snes_cur;
    case (gnt_own)
      OWN_MCU: win = mk_req(MCU_ADDR, MCU_WE, MCU_WDATA);
      OWN_GSU: win = mk_req(GSU_ADDR, GSU_WE, GSU_WDATA);
      default: win = snes_cur;
    endcase
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:   if (gnt_vld) nstate = ST_ACCESS;
      ST_ACCESS: if (cnt == 4'd0) nstate = ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= ST_IDLE;
    else     state <= nstate;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= 4'd0;
      owner      <= OWN_SNES;
      acc_we     <= 1'b0;
      starve     <= 2'd0;
      snes_pend  <= 1'b0;
      snes_q     <= '0;
      MEM_ADDR   <= 24'd0;
      MEM_WDATA  <= 8'd0;
      SNES_RDATA <= 8'd0;
      MCU_RDATA  <= 8'd0;
      GSU_RDATA  <= 8'd0;
      SNES_RDY   <= 1'b0;
      MCU_ACK    <= 1'b0;
      GSU_ACK    <= 1'b0;
    end else begin
      SNES_RDY <= 1'b0;
      MCU_ACK  <= 1'b0;
      GSU_ACK  <= 1'b0;
      if (SNES_REQ) begin
        snes_pend <= 1'b1;
        snes_q    <= snes_cur;
      end
      if (grant) begin
        owner     <= gnt_own;
        MEM_ADDR  <= win.addr;
        MEM_WDATA <= win.wdata;
        acc_we    <= win.we;
        cnt       <= CNT_LOAD;
        if (gnt_own == OWN_SNES) snes_pend <= 1'b0;
        if (gnt_own == OWN_GSU)
          starve <= 2'd0;
        else if (gnt_own == OWN_MCU && GSU_REQ && starve != 2'd3)
          starve <= starve + 2'd1;
      end else if (state == ST_ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          case (owner)
            OWN_MCU: begin
              MCU_ACK <= 1'b1;
              if (!acc_we) MCU_RDATA <= MEM_RDATA;
            end
            OWN_GSU: begin
              GSU_ACK <= 1'b1;
              if (!acc_we) GSU_RDATA <= MEM_RDATA;
            end
            default: begin
              SNES_RDY <= 1'b1;
              if (!acc_we) SNES_RDATA <= MEM_RDATA;
            end
          endcase
        end
      end
    end
  end

  // Strobes decode from registered state so reset drops them without waiting for a clock.
  assign MEM_OE = (state == ST_ACCESS) && !acc_we;
  assign MEM_WE = (state == ST_ACCESS) && acc_we && (cnt >= 4'd1) && (cnt <= WE_LAST);

endmodule

// File: tb/tb_gsu_mem_arbiter.sv
// Directed bench for gsu_mem_arbiter: vector table of single accesses plus multi-cycle sequences.
module tb_gsu_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SNES_REQ, SNES_WE, MCU_REQ, MCU_WE, GSU_REQ, GSU_WE;
  logic [23:0] SNES_ADDR, MCU_ADDR, GSU_ADDR, MEM_ADDR;
  logic [7:0]  SNES_WDATA, MCU_WDATA, GSU_WDATA, MEM_WDATA, MEM_RDATA;
  logic [7:0]  SNES_RDATA, MCU_RDATA, GSU_RDATA;
  logic        SNES_RDY, MCU_ACK, GSU_ACK, MEM_OE, MEM_WE;

  int n_cmp = 0;
  int n_bad = 0;

  gsu_mem_arbiter #(.ACCESS_CYCLES(6), .STARVE_LIMIT(2)) dut (
    .CLK(CLK), .RST(RST),
    .SNES_REQ(SNES_REQ), .SNES_ADDR(SNES_ADDR), .SNES_WE(SNES_WE), .SNES_WDATA(SNES_WDATA),
    .SNES_RDATA(SNES_RDATA), .SNES_RDY(SNES_RDY),
    .MCU_REQ(MCU_REQ), .MCU_ADDR(MCU_ADDR), .MCU_WE(MCU_WE), .MCU_WDATA(MCU_WDATA),
    .MCU_RDATA(MCU_RDATA), .MCU_ACK(MCU_ACK),
    .GSU_REQ(GSU_REQ), .GSU_ADDR(GSU_ADDR), .GSU_WE(GSU_WE), .GSU_WDATA(GSU_WDATA),
    .GSU_RDATA(GSU_RDATA), .GSU_ACK(GSU_ACK),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .MEM_OE(MEM_OE), .MEM_WE(MEM_WE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          who;     // 0 SNES, 1 MCU, 2 GSU
    logic [23:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [7:0]  mrd;
    logic [7:0]  exp_rd;
    int          exp_lat;
    int          exp_oe;
    int          exp_we;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {3'b0, SNES_RDATA, SNES_RDY, MCU_RDATA, MCU_ACK, GSU_RDATA, GSU_ACK,
            MEM_ADDR, MEM_WDATA, MEM_OE, MEM_WE};
  endfunction

  // Called right after a falling edge; returns right after a falling edge.
  task automatic run_one(input vec_t v, input int idx);
    int lat = 0, oe = 0, we = 0;
    logic ok = 1'b1, got = 1'b0;
    logic [7:0] rd;
    MEM_RDATA = v.mrd;
    case (v.who)
      0: begin SNES_REQ = 1; SNES_ADDR = v.addr; SNES_WE = v.we; SNES_WDATA = v.wd; end
      1: begin MCU_REQ = 1; MCU_ADDR = v.addr; MCU_WE = v.we; MCU_WDATA = v.wd; end
      default: begin GSU_REQ = 1; GSU_ADDR = v.addr; GSU_WE = v.we; GSU_WDATA = v.wd; end
    endcase
    while (!got && lat < 20) begin
      @(negedge CLK);
      SNES_REQ = 0;
      lat++;
      if (MEM_OE || MEM_WE) begin
        if (MEM_ADDR !== v.addr) ok = 1'b0;
        if (MEM_WE && MEM_WDATA !== v.wd) ok = 1'b0;
      end
      oe += int'(MEM_OE);
      we += int'(MEM_WE);
      case (v.who)
        0: got = SNES_RDY;
        1: begin got = MCU_ACK; if (got) MCU_REQ = 0; end
        default: begin got = GSU_ACK; if (got) GSU_REQ = 0; end
      endcase
    end
    MCU_REQ = 0;
    GSU_REQ = 0;
    rd = (v.who == 0) ? SNES_RDATA : (v.who == 1) ? MCU_RDATA : GSU_RDATA;
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d_oe_cycles", idx), 64'(oe), 64'(v.exp_oe));
    chk($sformatf("v%0d_we_cycles", idx), 64'(we), 64'(v.exp_we));
    chk($sformatf("v%0d_rdata", idx), 64'(rd), 64'(v.exp_rd));
    chk($sformatf("v%0d_addr_data_stable", idx), 64'(ok), 64'd1);
    @(negedge CLK);
  endtask

  vec_t vt[6];

  initial begin
    int c, gack, srdy, we_n, rdy_n, pulse_at;
    logic ok;
    int ord[$];
    int exp_ord[6];

    vt[0] = '{1, 24'h000123, 1'b0, 8'h00, 8'hA5, 8'hA5, 7, 6, 0};
    vt[1] = '{2, 24'h123456, 1'b0, 8'h00, 8'h5A, 8'h5A, 7, 6, 0};
    vt[2] = '{1, 24'h00FFFF, 1'b1, 8'h77, 8'hEE, 8'hA5, 7, 0, 4};
    vt[3] = '{2, 24'hE00010, 1'b1, 8'h3C, 8'h11, 8'h5A, 7, 0, 4};
    vt[4] = '{0, 24'h7E8000, 1'b0, 8'h00, 8'hC3, 8'hC3, 7, 6, 0};
    vt[5] = '{0, 24'h008000, 1'b1, 8'h99, 8'h00, 8'hC3, 7, 0, 4};

    RST = 1;
    SNES_REQ = 0; SNES_ADDR = 0; SNES_WE = 0; SNES_WDATA = 0;
    MCU_REQ = 0; MCU_ADDR = 0; MCU_WE = 0; MCU_WDATA = 0;
    GSU_REQ = 0; GSU_ADDR = 0; GSU_WE = 0; GSU_WDATA = 0;
    MEM_RDATA = 8'hFF;
    @(negedge CLK); @(negedge CLK);
    chk("reset_outputs", all_outs(), 64'd0);
    RST = 0;
    @(negedge CLK);
    chk("idle_outputs", all_outs(), 64'd0);

    foreach (vt[i]) run_one(vt[i], i);

    // SNES write arrives during a GSU read: granted in the GSU_ACK cycle.
    MEM_RDATA = 8'h66;
    GSU_REQ = 1; GSU_ADDR = 24'h000400; GSU_WE = 0;
    gack = 0; srdy = 0; we_n = 0; ok = 1'b1;
    for (c = 1; c <= 40 && srdy == 0; c++) begin
      @(negedge CLK);
      SNES_REQ = 0;
      if (c == 2) begin SNES_REQ = 1; SNES_ADDR = 24'hE00010; SNES_WE = 1; SNES_WDATA = 8'h3C; end
      if (GSU_ACK) begin gack = c; GSU_REQ = 0; end
      if (gack != 0 && c == gack + 1) chk("snes_grant_in_ack_cycle", 64'(MEM_ADDR), 64'hE00010);
      if (MEM_WE) begin
        we_n++;
        if (MEM_WDATA !== 8'h3C || MEM_ADDR !== 24'hE00010) ok = 1'b0;
      end
      if (SNES_RDY) srdy = c;
    end
    chk("gsu_ack_cycle", 64'(gack), 64'd7);
    chk("gsu_rdata", 64'(GSU_RDATA), 64'h66);
    chk("snes_rdy_cycle", 64'(srdy), 64'd14);
    chk("snes_we_cycles", 64'(we_n), 64'd4);
    chk("snes_we_data", 64'(ok), 64'd1);
    @(negedge CLK);

    // Two SNES pulses during one MCU access collapse into one access with the later values.
    MEM_RDATA = 8'h12;
    MCU_REQ = 1; MCU_ADDR = 24'h000010; MCU_WE = 0;
    rdy_n = 0; we_n = 0; ok = 1'b1;
    for (c = 1; c <= 30; c++) begin
      @(negedge CLK);
      SNES_REQ = 0;
      if (c == 2) begin SNES_REQ = 1; SNES_ADDR = 24'h008000; SNES_WE = 1; SNES_WDATA = 8'h11; end
      if (c == 4) begin SNES_REQ = 1; SNES_ADDR = 24'h008001; SNES_WE = 1; SNES_WDATA = 8'h22; end
      if (MCU_ACK) MCU_REQ = 0;
      if (MEM_WE) begin
        we_n++;
        if (MEM_ADDR !== 24'h008001 || MEM_WDATA !== 8'h22) ok = 1'b0;
      end
      rdy_n += int'(SNES_RDY);
    end
    chk("dbl_snes_rdy_count", 64'(rdy_n), 64'd1);
    chk("dbl_snes_we_cycles", 64'(we_n), 64'd4);
    chk("dbl_snes_last_addr", 64'(ok), 64'd1);
    chk("dbl_mcu_rdata", 64'(MCU_RDATA), 64'h12);

    // Starvation guard: SNES accesses let the MCU win twice while GSU waits; the third pick goes to GSU.
    exp_ord = '{1, 0, 1, 0, 2, 1};
    MEM_RDATA = 8'h00;
    MCU_REQ = 1; MCU_WE = 0; GSU_REQ = 1; GSU_WE = 0;
    SNES_WE = 0;
    pulse_at = -1;
    for (c = 1; c <= 120 && ord.size() < 6; c++) begin
      @(negedge CLK);
      SNES_REQ = 0;
      if (MCU_ACK) ord.push_back(1);
      if (GSU_ACK) ord.push_back(2);
      if (SNES_RDY) begin
        ord.push_back(0);
        if (ord.size() == 2) pulse_at = c + 2;
      end
      if (c == 2 || c == pulse_at) begin SNES_REQ = 1; SNES_ADDR = 24'h00C000; end
    end
    MCU_REQ = 0; GSU_REQ = 0;
    chk("starve_grant_count", 64'(ord.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("starve_order_%0d", i), (i < ord.size()) ? 64'(ord[i]) : 64'hF, 64'(exp_ord[i]));
    repeat (3) @(negedge CLK);

    // Reset in the third cycle of a GSU write aborts it with no ACK.
    GSU_REQ = 1; GSU_ADDR = 24'h000777; GSU_WE = 1; GSU_WDATA = 8'hAB;
    repeat (3) @(negedge CLK);
    chk("rst_pre_we", 64'(MEM_WE), 64'd1);
    RST = 1;
    #1;
    chk("rst_async_outputs", all_outs(), 64'd0);
    GSU_REQ = 0;
    @(negedge CLK);
    RST = 0;
    ok = 1'b0;
    for (c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (GSU_ACK || MEM_WE || MEM_OE) ok = 1'b1;
    end
    chk("rst_no_ack", 64'(ok), 64'd0);
    run_one('{1, 24'h000123, 1'b0, 8'h00, 8'hA5, 8'hA5, 7, 6, 0}, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
